cnn_seq_controller: RTL and testbench

Top-level sequencer for the 1-D CNN ECG classifier. Launches all conv/pool stages, collects the final pooled feature map from NUM_CH parallel channels into an internal buffer, and streams the buffer to the fully-connected engine in FC_LANES-wide beats. It then runs a sequential signed argmax over the FC class scores and presents the class ID and segment code. Adds parameterisation, timeout/count error detection, deterministic tie-break and a clean abort path.

---
 rtl/cnn_seq_controller.sv | 274 +++++++++++++++++++++++++++
 tb/tb_cnn_seq_controller.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_seq_controller.sv
// cnn_seq_controller
//   Top-level sequencer for the 1-D CNN ECG classifier. Launches the conv/pool
//   stages, gathers the final pooled feature map into a local buffer, streams
//   it to the FC engine, then runs a sequential signed argmax over the class
//   scores and presents the winning class ID and its one-hot segment code.
//
// Ports
//   clk_i, rst_i    clock, synchronous active-high reset
//   main_start_i    inference request (accepted only in IDLE)
//   stage_done_i    last conv/pool stage finished
//   maxflag_i       ch_data_i valid this cycle
//   ch_data_i       NUM_CH feature words, ch0 in LSBs
//   start_o         one-cycle launch pulse per stage
//   fc_en_o         fc_data_o valid
//   fc_first_o      first FC beat marker
//   fc_data_o       FC_LANES buffer words, lowest index in LSBs
//   fc_done_i       fc_score_i valid
//   fc_score_i      NUM_CLASSES signed scores, class0 in LSBs
//   busy_o          high in every state except IDLE
//   class_valid_o   one-cycle result pulse
//   class_id_o      winning class
//   seg_o           one-hot of class_id_o, held until next result
//   err_timeout_o   sticky, COLLECT/WAIT_FC ran too long
//   err_count_o     sticky, wrong number of maxflag beats
//
// state    | meaning
// IDLE     | waiting for main_start
// COLLECT  | stages running, storing maxflag beats into the buffer
// FEED     | streaming the buffer to the FC engine, one beat per cycle
// WAIT_FC  | waiting for fc_done
// CLASSIFY | argmax, one class per cycle
// DONE     | result pulse
module cnn_seq_controller #(
  parameter int NUM_CH      = 16,
  parameter int DATA_W      = 8,
  parameter int NUM_WRITES  = 4,
  parameter int FC_LANES    = 4,
  parameter int NUM_STAGES  = 4,
  parameter int NUM_CLASSES = 5,
  parameter int SCORE_W     = 16,
  parameter int TIMEOUT     = 1048575
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            main_start_i,
  input  logic                            stage_done_i,
  input  logic                            maxflag_i,
  input  logic [NUM_CH*DATA_W-1:0]        ch_data_i,
  output logic [NUM_STAGES-1:0]           start_o,
  output logic                            fc_en_o,
  output logic                            fc_first_o,
  output logic [FC_LANES*DATA_W-1:0]      fc_data_o,
  input  logic                            fc_done_i,
  input  logic [NUM_CLASSES*SCORE_W-1:0]  fc_score_i,
  output logic                            busy_o,
  output logic                            class_valid_o,
  output logic [2:0]                      class_id_o,
  output logic [7:0]                      seg_o,
  output logic                            err_timeout_o,
  output logic                            err_count_o
);

  localparam int BUF_DEPTH = NUM_CH * NUM_WRITES;
  localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int FC_BEATS  = BUF_DEPTH / FC_LANES;
  localparam int BEAT_W    = $clog2(FC_BEATS + 1);
  localparam int WCNT_W    = $clog2(NUM_WRITES + 1);
  localparam int TIMER_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, COLLECT, FEED, WAIT_FC, CLASSIFY, DONE
  } state_t;

  state_t                           state_q, state_d;
  logic [WCNT_W-1:0]                wcnt_q, wcnt_d;
  logic [TIMER_W-1:0]               timer_q, timer_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;
  logic [2:0]                       cls_q, cls_d;
  logic [NUM_CLASSES*SCORE_W-1:0]   scores_q, scores_d;
  logic signed [SCORE_W-1:0]        best_score_q, best_score_d;
  logic [2:0]                       best_id_q, best_id_d;
  logic [NUM_STAGES-1:0]            start_q, start_d;
  logic                             fc_en_q, fc_en_d;
  logic                             fc_first_q, fc_first_d;
  logic [FC_LANES*DATA_W-1:0]       fc_data_q, fc_data_d;
  logic                             busy_q, busy_d;
  logic                             class_valid_q, class_valid_d;
  logic [2:0]                       class_id_q, class_id_d;
  logic [7:0]                       seg_q, seg_d;
  logic                             err_timeout_q, err_timeout_d;
  logic                             err_count_q, err_count_d;

  logic [DATA_W-1:0]                buf_q [BUF_DEPTH];
  logic                             wr_en;
  logic                             overflow;
  logic [BEAT_W-1:0]                rd_beat;
  logic [FC_LANES*DATA_W-1:0]       rd_data;
  logic signed [SCORE_W-1:0]        cur_score;

  assign wr_en    = (state_q == COLLECT) && maxflag_i && (wcnt_q < WCNT_W'(NUM_WRITES));
  assign overflow = (state_q == COLLECT) && maxflag_i && (wcnt_q == WCNT_W'(NUM_WRITES));
  // Beat 0 is fetched on the COLLECT->FEED edge, everything else from beat_q.
  assign rd_beat  = (state_q == COLLECT) ? '0 : beat_q;
  assign cur_score = scores_q[int'(cls_q)*SCORE_W +: SCORE_W];

  // Read mux with write-through: a beat stored in the same cycle as
  // stage_done must already be visible in the first FC beat.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < FC_LANES; k++) begin
      rd_data[k*DATA_W +: DATA_W] = buf_q[BUF_AW'(int'(rd_beat)*FC_LANES + k)];
      if (wr_en && (((int'(rd_beat)*FC_LANES + k) / NUM_CH) == int'(wcnt_q)))
        rd_data[k*DATA_W +: DATA_W] =
          ch_data_i[((int'(rd_beat)*FC_LANES + k) % NUM_CH)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    timer_d       = timer_q;
    beat_d        = beat_q;
    cls_d         = cls_q;
    scores_d      = scores_q;
    best_score_d  = best_score_q;
    best_id_d     = best_id_q;
    start_d       = '0;
    fc_en_d       = 1'b0;
    fc_first_d    = 1'b0;
    fc_data_d     = fc_data_q;
    class_valid_d = 1'b0;
    class_id_d    = class_id_q;
    seg_d         = seg_q;
    err_timeout_d = err_timeout_q;
    err_count_d   = err_count_q;

    case (state_q)
      IDLE: begin
        if (main_start_i) begin
          state_d       = COLLECT;
          start_d       = '1;
          err_timeout_d = 1'b0;
          err_count_d   = 1'b0;
          wcnt_d        = '0;
          timer_d       = TIMER_W'(TIMEOUT - 1);
        end
      end
      COLLECT: begin
        if (wr_en) wcnt_d = wcnt_q + WCNT_W'(1);
        if (overflow) err_count_d = 1'b1;
        if (stage_done_i) begin
          if (wcnt_d == WCNT_W'(NUM_WRITES) && !overflow && !err_count_q) begin
            state_d    = FEED;
            fc_en_d    = 1'b1;
            fc_first_d = 1'b1;
            fc_data_d  = rd_data;
            beat_d     = BEAT_W'(1);
          end else begin
            err_count_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (timer_q == '0) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      FEED: begin
        if (beat_q < BEAT_W'(FC_BEATS)) begin
          fc_en_d   = 1'b1;
          fc_data_d = rd_data;
          beat_d    = beat_q + BEAT_W'(1);
        end else begin
          state_d = WAIT_FC;
          timer_d = TIMER_W'(TIMEOUT - 1);
        end
      end
      WAIT_FC: begin
        if (fc_done_i) begin
          scores_d = fc_score_i;
          cls_d    = '0;
          state_d  = CLASSIFY;
        end else if (timer_q == '0) begin
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      CLASSIFY: begin
        // Strictly greater: ties keep the lower class index.
        if (cls_q == '0 || cur_score > best_score_q) begin
          best_score_d = cur_score;
          best_id_d    = cls_q;
        end
        if (cls_q == 3'(NUM_CLASSES - 1)) begin
          state_d       = DONE;
          class_valid_d = 1'b1;
          class_id_d    = best_id_d;
          seg_d         = 8'(1) << best_id_d;
        end else begin
          cls_d = cls_q + 3'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wcnt_q        <= '0;
      timer_q       <= '0;
      beat_q        <= '0;
      cls_q         <= '0;
      scores_q      <= '0;
      best_score_q  <= '0;
      best_id_q     <= '0;
      start_q       <= '0;
      fc_en_q       <= 1'b0;
      fc_first_q    <= 1'b0;
      fc_data_q     <= '0;
      busy_q        <= 1'b0;
      class_valid_q <= 1'b0;
      class_id_q    <= '0;
      seg_q         <= '0;
      err_timeout_q <= 1'b0;
      err_count_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wcnt_q        <= wcnt_d;
      timer_q       <= timer_d;
      beat_q        <= beat_d;
      cls_q         <= cls_d;
      scores_q      <= scores_d;
      best_score_q  <= best_score_d;
      best_id_q     <= best_id_d;
      start_q       <= start_d;
      fc_en_q       <= fc_en_d;
      fc_first_q    <= fc_first_d;
      fc_data_q     <= fc_data_d;
      busy_q        <= busy_d;
      class_valid_q <= class_valid_d;
      class_id_q    <= class_id_d;
      seg_q         <= seg_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  // Feature buffer is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en) begin
      for (int k = 0; k < NUM_CH; k++)
        buf_q[BUF_AW'(int'(wcnt_q)*NUM_CH + k)] <= ch_data_i[k*DATA_W +: DATA_W];
    end
  end

  assign start_o       = start_q;
  assign fc_en_o       = fc_en_q;
  assign fc_first_o    = fc_first_q;
  assign fc_data_o     = fc_data_q;
  assign busy_o        = busy_q;
  assign class_valid_o = class_valid_q;
  assign class_id_o    = class_id_q;
  assign seg_o         = seg_q;
  assign err_timeout_o = err_timeout_q;
  assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_cnn_seq_controller.sv
module tb_cnn_seq_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         main_start = 1'b0;
  logic         stage_done = 1'b0;
  logic         maxflag = 1'b0;
  logic [127:0] ch_data = '0;
  logic         fc_done = 1'b0;
  logic [79:0]  fc_score = '0;

  logic [3:0]   start_o;
  logic         fc_en, fc_first, busy, class_valid, err_timeout, err_count;
  logic [31:0]  fc_data;
  logic [2:0]   class_id;
  logic [7:0]   seg;

  logic [3:0]   to_start;
  logic         to_fc_en, to_fc_first, to_busy, to_class_valid, to_err_timeout, to_err_count;
  logic [31:0]  to_fc_data;
  logic [2:0]   to_class_id;
  logic [7:0]   to_seg;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] data;
    logic        first;
  } fc_exp_t;

  fc_exp_t     fc_q[$];
  int          exp_cls_q[$];
  logic [7:0]  mbuf [64];

  always #5 clk = ~clk;

  cnn_seq_controller u_dut (
    .clk_i(clk), .rst_i(rst), .main_start_i(main_start), .stage_done_i(stage_done),
    .maxflag_i(maxflag), .ch_data_i(ch_data), .start_o(start_o), .fc_en_o(fc_en),
    .fc_first_o(fc_first), .fc_data_o(fc_data), .fc_done_i(fc_done), .fc_score_i(fc_score),
    .busy_o(busy), .class_valid_o(class_valid), .class_id_o(class_id), .seg_o(seg),
    .err_timeout_o(err_timeout), .err_count_o(err_count)
  );

  cnn_seq_controller #(.TIMEOUT(100)) u_to (
    .clk_i(clk), .rst_i(rst), .main_start_i(main_start), .stage_done_i(stage_done),
    .maxflag_i(maxflag), .ch_data_i(ch_data), .start_o(to_start), .fc_en_o(to_fc_en),
    .fc_first_o(to_fc_first), .fc_data_o(to_fc_data), .fc_done_i(fc_done), .fc_score_i(fc_score),
    .busy_o(to_busy), .class_valid_o(to_class_valid), .class_id_o(to_class_id), .seg_o(to_seg),
    .err_timeout_o(to_err_timeout), .err_count_o(to_err_count)
  );

  // Scoreboard consumer: FC beats and class results are popped as they appear.
  always @(negedge clk) begin
    fc_exp_t e;
    int      id;
    if (fc_en === 1'b1) begin
      vectors++;
      if (fc_q.size() == 0) begin
        miscompares++;
        $display("FAIL fc_unexpected: fc_en high with data %h, no beat expected", fc_data);
      end else begin
        e = fc_q.pop_front();
        if (fc_data !== e.data || fc_first !== e.first) begin
          miscompares++;
          $display("FAIL fc_beat: got data %h first %b, expected data %h first %b",
                   fc_data, fc_first, e.data, e.first);
        end
      end
    end
    if (class_valid === 1'b1) begin
      vectors++;
      if (exp_cls_q.size() == 0) begin
        miscompares++;
        $display("FAIL class_unexpected: class_valid with id %0d, no result expected", class_id);
      end else begin
        id = exp_cls_q.pop_front();
        if (class_id !== 3'(id) || seg !== (8'(1) << id)) begin
          miscompares++;
          $display("FAIL class_result: got id %0d seg %b, expected id %0d seg %b",
                   class_id, seg, id, 8'(1) << id);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    main_start = 1'b1;
    cyc();
    main_start = 1'b0;
  endtask

  task automatic push_feed(input int nbeats);
    fc_exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.first = (b == 0);
      for (int k = 0; k < 4; k++) e.data[k*8 +: 8] = mbuf[b*4 + k];
      fc_q.push_back(e);
    end
  endtask

  // One maxflag beat; with_done also raises stage_done in the same cycle.
  task automatic send_beat(input int row, input int seed, input bit with_done);
    for (int k = 0; k < 16; k++) begin
      ch_data[k*8 +: 8] = 8'(seed + row*16 + k);
      if (row < 4) mbuf[row*16 + k] = 8'(seed + row*16 + k);
    end
    if (with_done) push_feed(16);
    maxflag    = 1'b1;
    stage_done = with_done;
    cyc();
    maxflag    = 1'b0;
    stage_done = 1'b0;
  endtask

  task automatic collect_ok(input int seed);
    pulse_start();
    for (int r = 0; r < 4; r++) send_beat(r, seed, 1'b0);
    push_feed(16);
    stage_done = 1'b1;
    cyc();
    stage_done = 1'b0;
    repeat (20) cyc();
  endtask

  task automatic classify(input int s0, input int s1, input int s2, input int s3, input int s4);
    int sc[5];
    int ei;
    int n;
    sc = '{s0, s1, s2, s3, s4};
    ei = 0;
    for (int i = 1; i < 5; i++) if (sc[i] > sc[ei]) ei = i;
    for (int i = 0; i < 5; i++) fc_score[i*16 +: 16] = 16'(sc[i]);
    exp_cls_q.push_back(ei);
    fc_done = 1'b1;
    cyc();
    fc_done = 1'b0;
    n = 1;
    while (class_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    vectors++;
    if (n != 6) begin
      miscompares++;
      $display("FAIL class_latency: got %0d cycles, expected 6", n);
    end
    cyc();
    vectors++;
    if (class_valid !== 1'b0 || busy !== 1'b0 || class_id !== 3'(ei) || seg !== (8'(1) << ei)) begin
      miscompares++;
      $display("FAIL class_hold: got valid %b busy %b id %0d seg %b, expected 0 0 %0d %b",
               class_valid, busy, class_id, seg, ei, 8'(1) << ei);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) cyc();
    vectors++;
    if (start_o !== 4'h0 || fc_en !== 1'b0 || fc_first !== 1'b0 || fc_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fc: got start %h fc_en %b first %b data %h, expected all 0",
               start_o, fc_en, fc_first, fc_data);
    end
    vectors++;
    if (busy !== 1'b0 || class_valid !== 1'b0 || class_id !== 3'd0 || seg !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_class: got busy %b valid %b id %0d seg %h, expected all 0",
               busy, class_valid, class_id, seg);
    end
    vectors++;
    if (err_timeout !== 1'b0 || err_count !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err: got tmo %b cnt %b, expected 0 0", err_timeout, err_count);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_normal();
    int    n;
    bit    gap, ended;
    logic [31:0] beat3;
    pulse_start();
    vectors++;
    if (start_o !== 4'hF || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_pulse: got start %h busy %b, expected f 1", start_o, busy);
    end
    cyc();
    vectors++;
    if (start_o !== 4'h0) begin
      miscompares++;
      $display("FAIL start_width: got %h, expected 0", start_o);
    end
    for (int r = 0; r < 4; r++) send_beat(r, 0, 1'b0);
    push_feed(16);
    stage_done = 1'b1;
    cyc();
    stage_done = 1'b0;
    vectors++;
    if (fc_en !== 1'b1 || fc_first !== 1'b1) begin
      miscompares++;
      $display("FAIL feed_latency: got fc_en %b first %b, expected 1 1", fc_en, fc_first);
    end
    n = 0; gap = 0; ended = 0; beat3 = '0;
    for (int i = 0; i < 30; i++) begin
      if (fc_en === 1'b1) begin
        if (ended) gap = 1;
        if (n == 3) beat3 = fc_data;
        n++;
      end else if (n > 0) begin
        ended = 1;
      end
      cyc();
    end
    vectors++;
    if (n != 16 || gap) begin
      miscompares++;
      $display("FAIL feed_count: got %0d beats gap %b, expected 16 beats no gap", n, gap);
    end
    vectors++;
    if (beat3 !== 32'h0F0E0D0C) begin
      miscompares++;
      $display("FAIL feed_beat3: got %h, expected 0f0e0d0c", beat3);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_fc_busy: got %b, expected 1", busy);
    end
  endtask

  task automatic test_argmax();
    classify(-5, 100, 100, 7, -128);
    vectors++;
    if (class_id !== 3'd1 || seg !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL argmax_tie: got id %0d seg %b, expected 1 00000010", class_id, seg);
    end
    collect_ok(37);
    classify(-9, -3, -3, -20, -4);
    vectors++;
    if (class_id !== 3'd1) begin
      miscompares++;
      $display("FAIL argmax_neg: got id %0d, expected 1", class_id);
    end
  endtask

  task automatic test_count_err();
    pulse_start();
    for (int r = 0; r < 3; r++) send_beat(r, 11, 1'b0);
    stage_done = 1'b1;
    cyc();
    stage_done = 1'b0;
    vectors++;
    if (err_count !== 1'b1 || busy !== 1'b0 || fc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL short_count: got err %b busy %b fc_en %b, expected 1 0 0",
               err_count, busy, fc_en);
    end
    repeat (5) cyc();
    pulse_start();
    vectors++;
    if (err_count !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear: got %b, expected 0", err_count);
    end
    for (int r = 0; r < 4; r++) send_beat(r, 60, 1'b0);
    vectors++;
    if (err_count !== 1'b0) begin
      miscompares++;
      $display("FAIL four_beats_ok: got %b, expected 0", err_count);
    end
    send_beat(4, 60, 1'b0);
    vectors++;
    if (err_count !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_flag: got err %b busy %b, expected 1 1", err_count, busy);
    end
    stage_done = 1'b1;
    cyc();
    stage_done = 1'b0;
    vectors++;
    if (busy !== 1'b0 || fc_en !== 1'b0 || err_count !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_abort: got busy %b fc_en %b err %b, expected 0 0 1",
               busy, fc_en, err_count);
    end
    repeat (3) cyc();
  endtask

  task automatic test_rst_feed();
    pulse_start();
    for (int r = 0; r < 4; r++) send_beat(r, 90, 1'b0);
    push_feed(8);
    stage_done = 1'b1;
    cyc();
    stage_done = 1'b0;
    repeat (7) cyc();
    vectors++;
    if (fc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL feed_beat7: got fc_en %b, expected 1", fc_en);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vectors++;
    if (fc_en !== 1'b0 || busy !== 1'b0 || seg !== 8'h00 || class_id !== 3'd0) begin
      miscompares++;
      $display("FAIL rst_mid_feed: got fc_en %b busy %b seg %h id %0d, expected 0 0 00 0",
               fc_en, busy, seg, class_id);
    end
    cyc();
    collect_ok(150);
    classify(0, 0, 0, 0, 50);
  endtask

  task automatic test_same_cycle();
    pulse_start();
    for (int r = 0; r < 3; r++) send_beat(r, 200, 1'b0);
    send_beat(3, 200, 1'b1);
    vectors++;
    if (fc_en !== 1'b1 || fc_first !== 1'b1 || err_count !== 1'b0) begin
      miscompares++;
      $display("FAIL same_cycle: got fc_en %b first %b err %b, expected 1 1 0",
               fc_en, fc_first, err_count);
    end
    repeat (20) cyc();
    main_start = 1'b1;
    cyc();
    main_start = 1'b0;
    vectors++;
    if (start_o !== 4'h0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_ignored: got start %h busy %b, expected 0 1", start_o, busy);
    end
    classify(7, 7, 7, 7, 7);
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    pulse_start();
    repeat (99) cyc();
    vectors++;
    if (to_err_timeout !== 1'b0 || to_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got tmo %b busy %b, expected 0 1", to_err_timeout, to_busy);
    end
    cyc();
    vectors++;
    if (to_err_timeout !== 1'b1 || to_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fire: got tmo %b busy %b, expected 1 0", to_err_timeout, to_busy);
    end
    cyc();
    pulse_start();
    vectors++;
    if (to_err_timeout !== 1'b0 || to_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_clear: got tmo %b busy %b, expected 0 1", to_err_timeout, to_busy);
    end
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_argmax();
    test_count_err();
    test_rst_feed();
    test_same_cycle();
    test_timeout();
    vectors++;
    if (fc_q.size() != 0 || exp_cls_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d beats %0d classes pending, expected 0 0",
               fc_q.size(), exp_cls_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
